read_burst_responder: RTL

- Avalon-MM burst read slave: the responder end of the burst reads posted by the read master.
- Accepts read commands (byte address plus burstcount) into a small command FIFO.
- Sequences each burst into per-word reads on a fixed-latency local memory port.
- Returns data beats in order on readdata/readdatavalid.
- Sits between the fabric and on-chip RAM/register banks serviced by the read masters.

---
 rtl/read_burst_responder_pkg.sv | 15 +
 rtl/read_burst_cmd_fifo.sv | 42 ++++
 rtl/read_burst_responder.sv | 96 +++++++++
 3 files changed

// File: rtl/read_burst_responder_pkg.sv
// read_burst_pkg: shared FSM states, burst sizing helpers and command-entry type for read_burst_responder
package read_burst_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int CMD_ADDR_WIDTH = 10;
  localparam int CMD_COUNT_WIDTH = 3;
  function automatic int burst_offset_width(input int bcw);
    return bcw > 1 ? bcw - 1 : 1;
  endfunction
  localparam int MAX_BURST = 2 ** (CMD_COUNT_WIDTH - 1);
  localparam int BURST_OFFSET_WIDTH = burst_offset_width(CMD_COUNT_WIDTH);
  typedef struct packed {
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [CMD_COUNT_WIDTH-1:0] count;
  } cmd_t;
endpackage

// File: rtl/read_burst_cmd_fifo.sv
// read_burst_cmd_fifo: show-ahead synchronous command FIFO with occupancy count and registered full flag
module read_burst_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] count_n;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign count_n = count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
      count <= count_n;
      full <= count_n == (DEPTH_LOG2+1)'(DEPTH);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/read_burst_responder.sv
// read_burst_responder: Avalon-MM burst read slave over a fixed-latency memory; READ_BURST_RESPONDER_WRAP_EN wraps beats in a MAX_BURST window
module read_burst_responder
  import read_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_SIZE_LOG2 = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_ADDRESS_WIDTH = CMD_ADDR_WIDTH,
  parameter int BURST_COUNT_WIDTH = CMD_COUNT_WIDTH,
  parameter int CMD_FIFO_DEPTH_LOG2 = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_WIDTH-1:0]     slave_address,
  input  logic                         slave_read,
  input  logic [BURST_COUNT_WIDTH-1:0] slave_burstcount,
  output logic                         slave_waitrequest,
  output logic [DATA_WIDTH-1:0]        slave_readdata,
  output logic                         slave_readdatavalid,
  output logic [MEM_ADDRESS_WIDTH-1:0] mem_address,
  output logic                         mem_read,
  input  logic [DATA_WIDTH-1:0]        mem_readdata,
  output logic                         busy
);
  localparam int OFS_W = burst_offset_width(BURST_COUNT_WIDTH);
  state_t state, state_n;
  logic [MEM_ADDRESS_WIDTH-1:0] cur_addr, cur_addr_n, next_addr;
  logic [BURST_COUNT_WIDTH-1:0] remaining, remaining_n;
  logic [MEM_LATENCY-1:0] vpipe;
  logic [CMD_FIFO_DEPTH_LOG2:0] count;
  logic pop, empty, full, load, unused_addr_bits;
  cmd_t push_cmd, head;
  assign unused_addr_bits = ^{slave_address[WORD_SIZE_LOG2-1:0],
                              slave_address[ADDRESS_WIDTH-1:WORD_SIZE_LOG2+MEM_ADDRESS_WIDTH]};
  assign push_cmd = '{addr: slave_address[WORD_SIZE_LOG2 +: MEM_ADDRESS_WIDTH], count: slave_burstcount};
  read_burst_cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH_LOG2(CMD_FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(slave_read && !full),
    .pop(pop),
    .din(push_cmd),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
`ifdef READ_BURST_RESPONDER_WRAP_EN
  assign next_addr = {cur_addr[MEM_ADDRESS_WIDTH-1:OFS_W], cur_addr[OFS_W-1:0] + OFS_W'(1)};
`else
  assign next_addr = cur_addr + MEM_ADDRESS_WIDTH'(1);
`endif
  assign load = !empty && head.count != '0;
  always_comb begin
    state_n = state;
    cur_addr_n = cur_addr;
    remaining_n = remaining;
    pop = 1'b0;
    mem_read = 1'b0;
    if (state == IDLE) begin
      pop = !empty;
      state_n = load ? BURST : IDLE;
    end else begin
      mem_read = 1'b1;
      cur_addr_n = next_addr;
      remaining_n = remaining - BURST_COUNT_WIDTH'(1);
      if (remaining == BURST_COUNT_WIDTH'(1)) begin
        pop = load;
        state_n = load ? BURST : IDLE;
      end
    end
    cur_addr_n = (pop && load) ? head.addr : cur_addr_n;
    remaining_n = (pop && load) ? head.count : remaining_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      vpipe <= '0;
    end else begin
      state <= state_n;
      cur_addr <= cur_addr_n;
      remaining <= remaining_n;
      vpipe <= (vpipe << 1) | MEM_LATENCY'(mem_read);
    end
  end
  assign mem_address = cur_addr;
  assign slave_waitrequest = full;
  assign slave_readdata = mem_readdata;
  assign slave_readdatavalid = vpipe[MEM_LATENCY-1];
  assign busy = count != '0 || state != IDLE || |vpipe;
endmodule
